// File: rtl/seq_alu_pkg.sv
// Shared constants for the sequential ALU: opcode values, FSM states and the
// default opcode field width.
package seq_alu_pkg;

    localparam int unsigned OPW_DEFAULT = 4;

    localparam int unsigned OP_ADD   = 0;
    localparam int unsigned OP_SUB   = 1;
    localparam int unsigned OP_AND   = 2;
    localparam int unsigned OP_OR    = 3;
    localparam int unsigned OP_XOR   = 4;
    localparam int unsigned OP_SHL   = 5;
    localparam int unsigned OP_SHR   = 6;
    localparam int unsigned OP_PASSA = 7;

    typedef enum logic [2:0] {
        S_OP,
        S_A,
        S_B,
        S_EXEC,
        S_DONE
    } state_t;

endpackage

// File: rtl/seq_alu_param_if.sv
// Word-serial operand stream and registered result handshake of seq_alu_param.
// carry/zero exist only when SEQ_ALU_FLAGS_EN is defined.
interface seq_alu_param_if #(
    parameter int unsigned WIDTH = 8
);
    logic [WIDTH-1:0] alu_in;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] alu_out;
    logic             out_valid;
    logic             out_ready;
    logic             err;
`ifdef SEQ_ALU_FLAGS_EN
    logic             carry;
    logic             zero;
`endif

    modport master (
        output alu_in, in_valid, out_ready,
`ifdef SEQ_ALU_FLAGS_EN
        input  carry, zero,
`endif
        input  in_ready, alu_out, out_valid, err
    );

    modport slave (
        input  alu_in, in_valid, out_ready,
`ifdef SEQ_ALU_FLAGS_EN
        output carry, zero,
`endif
        output in_ready, alu_out, out_valid, err
    );

endinterface

// File: rtl/seq_alu_core.sv
// Combinational ALU datapath: opcode, A, B -> result, err (and carry when
// SEQ_ALU_FLAGS_EN is defined).
module seq_alu_core
    import seq_alu_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned OPW   = OPW_DEFAULT
) (
    input  logic [OPW-1:0]   op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result,
`ifdef SEQ_ALU_FLAGS_EN
    output logic             carry,
`endif
    output logic             err
);
    localparam int unsigned SHW = $clog2(WIDTH);

    logic [31:0]    op_ext;
    logic [SHW-1:0] sh;

    assign op_ext = 32'(op);
    assign sh     = b[SHW-1:0];

    always_comb begin
        result = '0;
        err    = 1'b0;
        case (op_ext)
            OP_ADD:   result = a + b;
            OP_SUB:   result = a - b;
            OP_AND:   result = a & b;
            OP_OR:    result = a | b;
            OP_XOR:   result = a ^ b;
            OP_SHL:   result = a << sh;
            OP_SHR:   result = a >> sh;
            OP_PASSA: result = a;
            default:  err    = 1'b1;
        endcase
    end

`ifdef SEQ_ALU_FLAGS_EN
    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    logic [31:0] shn;
    assign shn = 32'(sh);

    // A zero shift moves the probe bit out of range, so no bit is reported.
    always_comb begin
        carry = 1'b0;
        case (op_ext)
            OP_ADD:  carry = (result < a);
            OP_SUB:  carry = (a < b);
            OP_SHL:  carry = |(a & (ONE << (WIDTH - shn)));
            OP_SHR:  carry = (shn != 32'd0) && |(a & (ONE << (shn - 32'd1)));
            default: carry = 1'b0;
        endcase
    end
`endif

endmodule

// File: rtl/seq_alu_param.sv
// Sequential ALU taking opcode, A and B as successive words and returning a
// registered result; carry/zero flags are built only with SEQ_ALU_FLAGS_EN.
module seq_alu_param
    import seq_alu_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned OPW   = OPW_DEFAULT
) (
    input logic            clock,
    input logic            reset,
    seq_alu_param_if.slave bus
);
    state_t state, state_nxt;

    logic [OPW-1:0]   opcode_q;
    logic [WIDTH-1:0] a_q, b_q, res_q;
    logic             err_q;
    logic             accept, in_ready_c, out_valid_c;
    logic [WIDTH-1:0] core_res;
    logic             core_err;
`ifdef SEQ_ALU_FLAGS_EN
    logic             carry_q, zero_q, core_carry;
`endif

    always_comb begin
        state_nxt   = state;
        in_ready_c  = 1'b0;
        out_valid_c = 1'b0;
        case (state)
            S_OP: begin
                in_ready_c = 1'b1;
                if (bus.in_valid) state_nxt = S_A;
            end
            S_A: begin
                in_ready_c = 1'b1;
                if (bus.in_valid) state_nxt = S_B;
            end
            S_B: begin
                in_ready_c = 1'b1;
                if (bus.in_valid) state_nxt = S_EXEC;
            end
            S_EXEC: state_nxt = S_DONE;
            S_DONE: begin
                out_valid_c = 1'b1;
                if (bus.out_ready) state_nxt = S_OP;
            end
            default: state_nxt = S_OP;
        endcase
    end

    assign accept = in_ready_c & bus.in_valid;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= S_OP;
        else        state <= state_nxt;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            opcode_q <= '0;
            a_q      <= '0;
            b_q      <= '0;
            res_q    <= '0;
            err_q    <= 1'b0;
`ifdef SEQ_ALU_FLAGS_EN
            carry_q  <= 1'b0;
            zero_q   <= 1'b0;
`endif
        end else begin
            if (accept) begin
                case (state)
                    S_OP:    opcode_q <= bus.alu_in[OPW-1:0];
                    S_A:     a_q      <= bus.alu_in;
                    S_B:     b_q      <= bus.alu_in;
                    default: ;
                endcase
            end
            // Result and flags change only on the single execute edge.
            if (state == S_EXEC) begin
                res_q   <= core_res;
                err_q   <= core_err;
`ifdef SEQ_ALU_FLAGS_EN
                carry_q <= core_carry;
                zero_q  <= (core_res == '0);
`endif
            end
        end
    end

    seq_alu_core #(
        .WIDTH (WIDTH),
        .OPW   (OPW)
    ) u_core (
        .op     (opcode_q),
        .a      (a_q),
        .b      (b_q),
        .result (core_res),
`ifdef SEQ_ALU_FLAGS_EN
        .carry  (core_carry),
`endif
        .err    (core_err)
    );

    assign bus.in_ready  = in_ready_c;
    assign bus.out_valid = out_valid_c;
    assign bus.alu_out   = res_q;
    assign bus.err       = err_q;
`ifdef SEQ_ALU_FLAGS_EN
    assign bus.carry     = carry_q;
    assign bus.zero      = zero_q;
`endif

endmodule

// File: tb/tb_seq_alu_param.sv
// Self-checking bench for seq_alu_param at WIDTH=8 and WIDTH=16 against an
// arithmetic reference model; flag checks are compiled with SEQ_ALU_FLAGS_EN.
module tb_seq_alu_param;

    logic clock = 1'b0;
    logic reset;
    int   vectors    = 0;
    int   miscompares = 0;

    always #5 clock = ~clock;

    seq_alu_param_if #(.WIDTH(8))  b8 ();
    seq_alu_param_if #(.WIDTH(16)) b16 ();

    seq_alu_param #(.WIDTH(8), .OPW(4)) dut8 (
        .clock (clock),
        .reset (reset),
        .bus   (b8.slave)
    );

    seq_alu_param #(.WIDTH(16), .OPW(4)) dut16 (
        .clock (clock),
        .reset (reset),
        .bus   (b16.slave)
    );

    // Reference: plain integer arithmetic on the operation definitions.
    function automatic void model(input int w, input int unsigned op, input longint a,
                                  input longint b, output longint r, output bit c,
                                  output bit e);
        longint m;
        int     sh;
        m  = (longint'(1) << w) - 1;
        sh = int'(b % w);
        r  = 0;
        c  = 1'b0;
        e  = 1'b0;
        case (op)
            0: begin r = (a + b) & m; c = ((a + b) >> w) != 0; end
            1: begin r = (a - b) & m; c = (a < b); end
            2: r = a & b;
            3: r = a | b;
            4: r = a ^ b;
            5: begin r = (a << sh) & m; c = (sh > 0) ? (((a >> (w - sh)) & 1) != 0) : 1'b0; end
            6: begin r = a >> sh; c = (sh > 0) ? (((a >> (sh - 1)) & 1) != 0) : 1'b0; end
            7: r = a;
            default: begin r = 0; e = 1'b1; end
        endcase
    endfunction

    task automatic send8(input logic [7:0] w);
        int n;
        n = 0;
        @(negedge clock);
        b8.alu_in   = w;
        b8.in_valid = 1'b1;
        while (b8.in_ready !== 1'b1 && n < 40) begin
            @(negedge clock);
            n++;
        end
        vectors++;
        if (n >= 40) begin
            $display("FAIL send8_ready: in_ready=%b want 1 within 40 cycles", b8.in_ready);
            miscompares++;
        end
        @(posedge clock);
        #1;
        b8.in_valid = 1'b0;
    endtask

    task automatic wait_result8(output int lat);
        lat = 0;
        while (b8.out_valid !== 1'b1 && lat < 20) begin
            @(posedge clock);
            #1;
            lat++;
        end
    endtask

    task automatic run_op8(input logic [7:0] o, input logic [7:0] a, input logic [7:0] b,
                           output int lat);
        send8(o);
        send8(a);
        send8(b);
        wait_result8(lat);
    endtask

    task automatic consume8();
        @(negedge clock);
        b8.out_ready = 1'b1;
        @(posedge clock);
        #1;
        b8.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (2) @(negedge clock);
        vectors++;
        if (b8.in_ready !== 1'b1 || b8.out_valid !== 1'b0 || b8.alu_out !== 8'h00 || b8.err !== 1'b0) begin
            $display("FAIL reset8: rdy=%b vld=%b out=%h err=%b want 1 0 00 0",
                     b8.in_ready, b8.out_valid, b8.alu_out, b8.err);
            miscompares++;
        end
        vectors++;
        if (b16.in_ready !== 1'b1 || b16.out_valid !== 1'b0 || b16.alu_out !== 16'h0000 || b16.err !== 1'b0) begin
            $display("FAIL reset16: rdy=%b vld=%b out=%h err=%b want 1 0 0000 0",
                     b16.in_ready, b16.out_valid, b16.alu_out, b16.err);
            miscompares++;
        end
`ifdef SEQ_ALU_FLAGS_EN
        vectors++;
        if (b8.carry !== 1'b0 || b8.zero !== 1'b0) begin
            $display("FAIL reset_flags: carry=%b zero=%b want 0 0", b8.carry, b8.zero);
            miscompares++;
        end
`endif
        reset = 1'b1;
        @(negedge clock);
        vectors++;
        if (b8.in_ready !== 1'b1 || b8.out_valid !== 1'b0) begin
            $display("FAIL reset_release: rdy=%b vld=%b want 1 0", b8.in_ready, b8.out_valid);
            miscompares++;
        end
    endtask

    task automatic test_directed();
        int     lat;
        logic [7:0] ops [5][3];
        longint r;
        bit     c, e;
        ops = '{'{8'd0, 8'd200, 8'd100}, '{8'd1, 8'd1, 8'd1}, '{8'd1, 8'd3, 8'd5},
                '{8'd9, 8'd77, 8'd12}, '{8'd0, 8'd2, 8'd3}};
        for (int i = 0; i < 5; i++) begin
            run_op8(ops[i][0], ops[i][1], ops[i][2], lat);
            model(8, 32'(ops[i][0]) % 16, longint'(ops[i][1]), longint'(ops[i][2]), r, c, e);
            vectors++;
            if (lat != 1) begin
                $display("FAIL dir%0d_latency: %0d cycles after B accept want 1", i, lat);
                miscompares++;
            end
            vectors++;
            if (b8.alu_out !== 8'(r) || b8.err !== e) begin
                $display("FAIL dir%0d_result: out=%0d err=%b want %0d %b", i, b8.alu_out, b8.err, r, e);
                miscompares++;
            end
`ifdef SEQ_ALU_FLAGS_EN
            vectors++;
            if (b8.carry !== c || b8.zero !== (r == 0)) begin
                $display("FAIL dir%0d_flags: carry=%b zero=%b want %b %b", i, b8.carry, b8.zero, c, r == 0);
                miscompares++;
            end
`endif
            consume8();
            vectors++;
            if (b8.out_valid !== 1'b0 || b8.in_ready !== 1'b1) begin
                $display("FAIL dir%0d_release: vld=%b rdy=%b want 0 1", i, b8.out_valid, b8.in_ready);
                miscompares++;
            end
        end
    endtask

    task automatic test_stall();
        int lat;
        run_op8(8'd4, 8'h5A, 8'h0F, lat);
        @(negedge clock);
        b8.in_valid  = 1'b1;
        b8.alu_in    = 8'h77;
        b8.out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            vectors++;
            if (b8.out_valid !== 1'b1 || b8.alu_out !== 8'h55 || b8.in_ready !== 1'b0) begin
                $display("FAIL stall%0d: vld=%b out=%h rdy=%b want 1 55 0", i, b8.out_valid, b8.alu_out, b8.in_ready);
                miscompares++;
            end
        end
        b8.in_valid  = 1'b0;
        b8.out_ready = 1'b1;
        @(posedge clock);
        #1;
        b8.out_ready = 1'b0;
        run_op8(8'd7, 8'h33, 8'h00, lat);
        vectors++;
        if (b8.alu_out !== 8'h33 || b8.err !== 1'b0) begin
            $display("FAIL stall_after: out=%h err=%b want 33 0", b8.alu_out, b8.err);
            miscompares++;
        end
        consume8();
    endtask

    task automatic test_reset_mid();
        int lat;
        send8(8'd3);
        send8(8'h0F);
        @(negedge clock);
        reset = 1'b0;
        #1;
        vectors++;
        if (b8.alu_out !== 8'h00 || b8.err !== 1'b0 || b8.out_valid !== 1'b0 || b8.in_ready !== 1'b1) begin
            $display("FAIL reset_mid: out=%h err=%b vld=%b rdy=%b want 00 0 0 1",
                     b8.alu_out, b8.err, b8.out_valid, b8.in_ready);
            miscompares++;
        end
`ifdef SEQ_ALU_FLAGS_EN
        vectors++;
        if (b8.carry !== 1'b0 || b8.zero !== 1'b0) begin
            $display("FAIL reset_mid_flags: carry=%b zero=%b want 0 0", b8.carry, b8.zero);
            miscompares++;
        end
`endif
        @(negedge clock);
        reset = 1'b1;
        run_op8(8'd2, 8'hF0, 8'hFF, lat);
        vectors++;
        if (b8.alu_out !== 8'hF0 || b8.err !== 1'b0 || lat != 1) begin
            $display("FAIL reset_mid_after: out=%h err=%b lat=%0d want f0 0 1", b8.alu_out, b8.err, lat);
            miscompares++;
        end
        consume8();
    endtask

    task automatic test_random8();
        int         lat, stall;
        logic [7:0] o, a, b;
        longint     r, prev;
        bit         c, e;
        prev = 64'hF0;
        for (int i = 0; i < 150; i++) begin
            o = 8'($urandom);
            a = 8'($urandom);
            b = 8'($urandom);
            send8(o);
            send8(a);
            vectors++;
            if (b8.alu_out !== 8'(prev)) begin
                $display("FAIL rnd%0d_hold: out=%h want %h while loading", i, b8.alu_out, 8'(prev));
                miscompares++;
            end
            send8(b);
            wait_result8(lat);
            model(8, 32'(o) % 16, longint'(a), longint'(b), r, c, e);
            vectors++;
            if (lat != 1 || b8.alu_out !== 8'(r) || b8.err !== e) begin
                $display("FAIL rnd%0d: op=%0d a=%h b=%h out=%h err=%b lat=%0d want %h %b 1",
                         i, o, a, b, b8.alu_out, b8.err, lat, 8'(r), e);
                miscompares++;
            end
`ifdef SEQ_ALU_FLAGS_EN
            vectors++;
            if (b8.carry !== c || b8.zero !== (r == 0)) begin
                $display("FAIL rnd%0d_flags: op=%0d a=%h b=%h carry=%b zero=%b want %b %b",
                         i, o, a, b, b8.carry, b8.zero, c, r == 0);
                miscompares++;
            end
`endif
            stall = $urandom_range(0, 3);
            repeat (stall) @(negedge clock);
            consume8();
            prev = r;
        end
    endtask

    task automatic feed16(input logic [15:0] w0, input logic [15:0] w1, input logic [15:0] w2);
        logic [15:0] words [3];
        int          idx, cyc;
        logic        acc;
        words = '{w0, w1, w2};
        idx   = 0;
        cyc   = 0;
        while (idx < 3 && cyc < 100) begin
            @(negedge clock);
            b16.in_valid = (cyc % 2 == 0);
            b16.alu_in   = words[idx];
            acc          = b16.in_valid && b16.in_ready;
            @(posedge clock);
            if (acc) idx++;
            cyc++;
        end
        #1;
        b16.in_valid = 1'b0;
        vectors++;
        if (idx != 3) begin
            $display("FAIL feed16: accepted %0d words want 3", idx);
            miscompares++;
        end
    endtask

    task automatic test_width16();
        int          lat;
        logic [15:0] o, a, b;
        longint      r;
        bit          c, e;
        for (int i = 0; i < 41; i++) begin
            if (i == 0) begin
                o = 16'd5;
                a = 16'h0001;
                b = 16'd15;
            end else begin
                o = 16'($urandom);
                a = 16'($urandom);
                b = 16'($urandom);
            end
            feed16(o, a, b);
            lat = 0;
            while (b16.out_valid !== 1'b1 && lat < 20) begin
                @(posedge clock);
                #1;
                lat++;
            end
            model(16, 32'(o) % 16, longint'(a), longint'(b), r, c, e);
            vectors++;
            if (lat != 1 || b16.alu_out !== 16'(r) || b16.err !== e) begin
                $display("FAIL w16_%0d: op=%0d a=%h b=%h out=%h err=%b lat=%0d want %h %b 1",
                         i, o, a, b, b16.alu_out, b16.err, lat, 16'(r), e);
                miscompares++;
            end
`ifdef SEQ_ALU_FLAGS_EN
            vectors++;
            if (b16.carry !== c || b16.zero !== (r == 0)) begin
                $display("FAIL w16_%0d_flags: carry=%b zero=%b want %b %b", i, b16.carry, b16.zero, c, r == 0);
                miscompares++;
            end
`endif
            @(negedge clock);
            b16.out_ready = 1'b1;
            @(posedge clock);
            #1;
            b16.out_ready = 1'b0;
        end
    endtask

    initial begin
        b8.alu_in     = '0;
        b8.in_valid   = 1'b0;
        b8.out_ready  = 1'b0;
        b16.alu_in    = '0;
        b16.in_valid  = 1'b0;
        b16.out_ready = 1'b0;
        test_reset();
        test_directed();
        test_stall();
        test_reset_mid();
        test_random8();
        test_width16();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/seq_alu_param.md
SEQ_ALU_PARAM -- requirements
Module: seq_alu_param

Interface
REQ-001 SHALL provide parameter WIDTH, default 8, operand/result width in bits (legal range 4 to 32).
REQ-002 SHALL provide parameter OPW, default 4, number of low bits of the opcode word decoded as opcode (OPW <= WIDTH).
REQ-003 SHALL provide port clock, input, 1, sole clock; all state changes on its rising edge.
REQ-004 SHALL provide port reset, input, 1, asynchronous, active-low reset.
REQ-005 SHALL provide port alu_in, input, WIDTH, serial word input carrying the opcode, then A, then B.
REQ-006 SHALL provide port in_valid, input, 1, alu_in holds a valid word.
REQ-007 SHALL provide port in_ready, output, 1, block accepts a word this cycle.
REQ-008 SHALL provide port alu_out, output, WIDTH, registered result.
REQ-009 SHALL provide port out_valid, output, 1, alu_out holds an unconsumed result.
REQ-010 SHALL provide port out_ready, input, 1, consumer takes the result this cycle.
REQ-011 SHALL provide port err, output, 1, registered; last operation had an undefined opcode.
REQ-012 SHALL provide ports carry and zero, each output, 1, registered flags; present only under SEQ_ALU_FLAGS_EN.

Function
REQ-013 SHALL implement FSM states S_OP, S_A, S_B, S_EXEC and S_DONE.
REQ-014 SHALL drive in_ready=1 only in S_OP, S_A and S_B; a word is accepted on a rising edge with in_valid and in_ready both high.
REQ-015 SHALL capture alu_in[OPW-1:0] into the opcode register on acceptance in S_OP, then move to S_A; upper bits are ignored.
REQ-016 SHALL capture A in S_A (then go to S_B) and B in S_B (then go to S_EXEC) on acceptance; otherwise hold state and registers.
REQ-017 SHALL leave S_EXEC unconditionally after one cycle, registering result/err/flags on that edge and entering S_DONE; out_valid is therefore high in the second cycle after the B-accept edge.
REQ-018 SHALL hold out_valid=1 and alu_out, err and the flags stable in S_DONE until out_ready=1, then return to S_OP on that edge.
REQ-019 SHALL decode: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SHL, 6 SHR (logical), 7 PASSA; all results are modulo 2^WIDTH.
REQ-020 SHALL take the shift amount as B[$clog2(WIDTH)-1:0].
REQ-021 SHALL produce result 0 with err=1 for opcodes 8 and above; a defined opcode sets err=0.
REQ-022 SHALL keep alu_out, err and the flags unchanged outside the S_EXEC update edge, including while a new operand sequence is being loaded.
REQ-023 SHALL ignore in_valid in S_EXEC and S_DONE; the upstream stalls with no word dropped and none double-captured.

Reset
REQ-024 SHALL, while reset=0, force state S_OP and clear opcode, A, B, alu_out, err, carry and zero to 0, so out_valid=0 and in_ready=1 on release.
REQ-025 SHALL, when reset is asserted in any state mid-operation, discard the partial sequence; the first accepted word after release is an opcode.

Configuration
REQ-026 SHALL gate the carry and zero ports and their logic with macro SEQ_ALU_FLAGS_EN.
REQ-027 SHALL, with SEQ_ALU_FLAGS_EN defined, set carry to the ADD carry-out, the SUB borrow (A<B unsigned), or the last bit shifted out for SHL/SHR; carry=0 for other opcodes.
REQ-028 SHALL, with SEQ_ALU_FLAGS_EN defined, set zero=1 when the registered result equals 0.
REQ-029 SHALL, without SEQ_ALU_FLAGS_EN, omit the carry and zero ports with all other behaviour identical.

Structure
REQ-030 SHALL place the opcode constants (ADD..PASSA), the FSM state encodings and OPW's default in shared package seq_alu_pkg.
REQ-031 SHALL implement the datapath as combinational sub-module seq_alu_core (opcode, A, B -> result, carry, err), with the FSM and registers in seq_alu_param.

Verification
REQ-032 SHALL cover WIDTH=8 with words 0, 200, 100 -> alu_out=44, carry=1, zero=0, err=0, out_valid high in the second cycle after the B accept.
REQ-033 SHALL cover words 1, 1, 1 -> alu_out=0, zero=1, carry=0; and words 1, 3, 5 -> alu_out=254, carry=1.
REQ-034 SHALL cover opcode word 9 (any A, B) -> alu_out=0, err=1; the next ADD 2+3 -> 5 with err=0.
REQ-035 SHALL cover out_ready held low for 5 cycles with in_valid=1 -> out_valid stays 1, alu_out stable, in_ready=0, and no words captured.
REQ-036 SHALL cover reset asserted in S_B after loading op 3, A=0x0F -> all outputs 0; subsequent words 2, 0xF0, 0xFF give alu_out=0xF0.
REQ-037 SHALL cover WIDTH=16 with SHL of 0x0001 by 15 -> 0x8000 and carry=0, and in_valid toggled every other cycle producing correct capture.
